// File: rtl/serial_frame_collector.sv
// serial_frame_collector
//   Serial-to-parallel receiver. Samples serial_in once per divided tick,
//   waits for a start bit (1), then shifts in WIDTH data bits MSB-first and
//   hands the assembled frame to the consumer over a valid/ready handshake.
//   A completed frame that cannot be stored because an unconsumed frame is
//   still pending is dropped and sets the sticky overrun flag.
//
//   Optional feature macro: SERIAL_PARITY_CHECK_EN
//     defined   : one even-parity bit follows the data bits; a frame whose
//                 data XOR parity is 1 is dropped and parity_err pulses for
//                 one cycle.
//     undefined : frames end after WIDTH data bits, parity_err is tied 0.
//
// Ports
//   INPUTCLOCK   in   1      system clock, all state changes on posedge
//   reset_n      in   1      synchronous reset, ACTIVE HIGH despite the name
//   enable       in   1      1 = divider runs; 0 = divider and FSM hold
//   serial_in    in   1      serial line, idle 0, start bit 1
//   frame_ready  in   1      consumer accepts frame_out this cycle
//   frame_out    out  WIDTH  last accepted frame
//   frame_valid  out  1      frame_out holds an unconsumed frame
//   busy         out  1      FSM is not in IDLE
//   overrun      out  1      sticky: a completed frame was dropped
//   parity_err   out  1      one-cycle pulse on parity mismatch
module serial_frame_collector #(
    parameter int WIDTH = 5,
    parameter int DIV   = 6000000,
    parameter int CNT_W = 25
) (
    input  logic             INPUTCLOCK,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             serial_in,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame_out,
    output logic             frame_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);

`ifdef SERIAL_PARITY_CHECK_EN
    // The parity check needs the whole data word after the last data tick.
    localparam int SH_W = WIDTH;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    // Without parity the final bit comes straight from serial_in, so only
    // WIDTH-1 bits ever need to be held.
    localparam int SH_W = WIDTH - 1;
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic [BW-1:0]    bitcnt;
    logic [SH_W-1:0]  shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] frame_data;
    logic             frame_done;

    assign tick = enable && (div_cnt == DIV_LAST);
    assign busy = (state != IDLE);

    always_ff @(posedge INPUTCLOCK) begin
        if (reset_n) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        frame_done = 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
        shreg_next = {shreg[WIDTH-2:0], serial_in};
        frame_data = shreg;
        frame_done = tick && (state == PARITY) && !((^shreg) ^ serial_in);
`else
        shreg_next = {shreg, serial_in};
        frame_data = shreg_next;
        frame_done = tick && (state == SHIFT) && (bitcnt == BIT_LAST);
`endif
    end

`ifndef SERIAL_PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge INPUTCLOCK) begin
        if (reset_n) begin
            state       <= IDLE;
            bitcnt      <= '0;
            shreg       <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
            parity_err  <= 1'b0;
`endif
        end else begin
`ifdef SERIAL_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (serial_in) begin
                            state  <= SHIFT;
                            bitcnt <= '0;
                        end
                    end
                    SHIFT: begin
                        shreg  <= shreg_next[SH_W-1:0];
                        bitcnt <= bitcnt + BW'(1);
                        if (bitcnt == BIT_LAST) begin
`ifdef SERIAL_PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= IDLE;
`endif
                        end
                    end
`ifdef SERIAL_PARITY_CHECK_EN
                    PARITY: begin
                        state <= IDLE;
                        if ((^shreg) ^ serial_in) begin
                            parity_err <= 1'b1;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end

            // A completing frame is stored if the slot is empty or being
            // consumed at this same edge; otherwise it is lost.
            if (frame_done) begin
                if (!frame_valid || frame_ready) begin
                    frame_out   <= frame_data;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
